vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Drives hCount, vCount and bright into the game/block controllers.
- Receives their combinational 12-bit rgb and returns it to the VGA connector, registered and blanked, with hSync/vSync aligned to it.
- Produces frame_tick and game_tick enables so game logic can move objects at a visible rate without a derived clock.

---
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing, pixel pipeline and game tick enables
//
// Purpose:
//   Divides the system clock down to a pixel enable, runs the horizontal and
//   vertical raster counters, and returns the controllers' colour to the
//   connector one pixel later, blanked outside the active region, with the
//   sync pulses delayed by the same pixel so colour and sync stay aligned.
//   Also produces per-frame and per-N-frame single-clock enables for game logic.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst          asynchronous, active-high reset
//   rgb_in       {R,G,B} colour for the current hCount/vCount
//   hCount       horizontal pixel counter
//   vCount       line counter
//   bright       current pixel lies in the visible region
//   pix_en       one-clk pulse per pixel period
//   hSync/vSync  active-low syncs, registered
//   vga_r/g/b    registered, blanked colour to the connector
//   frame_tick   one-clk pulse while the counters sit at (0,0) after a frame wrap
//   game_tick    one-clk pulse every FRAMES_PER_TICK frames, coincident with frame_tick

module vga_timing_gen #(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_ACT_START     = 144,
  parameter int unsigned H_ACT_END       = 784,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_ACT_START     = 35,
  parameter int unsigned V_ACT_END       = 515,
  parameter int unsigned FRAMES_PER_TICK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        hSync,
  output logic        vSync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_tick,
  output logic        game_tick
);

  // A divide-by-1 still needs a one-bit divider register to keep widths legal.
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic [7:0]       r_frame_cnt;
  logic             r_hsync;
  logic             r_vsync;
  logic [3:0]       r_vga_r;
  logic [3:0]       r_vga_g;
  logic [3:0]       r_vga_b;
  logic             r_frame_tick;
  logic             r_game_tick;

  logic             w_pix_en;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame_wrap;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_bright;

  assign w_pix_en     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_h_last     = (r_h == 10'(H_TOTAL - 1));
  assign w_v_last     = (r_v == 10'(V_TOTAL - 1));
  assign w_frame_wrap = w_pix_en && w_h_last && w_v_last;

  assign w_h_act  = (r_h >= 10'(H_ACT_START)) && (r_h < 10'(H_ACT_END));
  assign w_v_act  = (r_v >= 10'(V_ACT_START)) && (r_v < 10'(V_ACT_END));
  assign w_bright = w_h_act && w_v_act;

  // Clock divider: pix_en is decoded from the terminal count, so the first
  // pixel advance lands on the CLK_DIV-th edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Raster counters; the line counter only moves on the horizontal wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v <= '0;
        end else begin
          r_v <= r_v + 10'd1;
        end
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // One-pixel output pipeline. Sync and colour are captured from the same
  // counter values on the same edge, which keeps them aligned at the connector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
    end else if (w_pix_en) begin
      r_hsync <= !(r_h < 10'(H_SYNC));
      r_vsync <= !(r_v < 10'(V_SYNC));
      if (w_bright) begin
        r_vga_r <= rgb_in[11:8];
        r_vga_g <= rgb_in[7:4];
        r_vga_b <= rgb_in[3:0];
      end else begin
        r_vga_r <= '0;
        r_vga_g <= '0;
        r_vga_b <= '0;
      end
    end
  end

  // Frame and game ticks are registered from the wrap decode so they are
  // visible for the single clk during which the counters read (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt  <= '0;
      r_frame_tick <= 1'b0;
      r_game_tick  <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      r_game_tick  <= 1'b0;
      if (w_frame_wrap) begin
        if (r_frame_cnt == 8'(FRAMES_PER_TICK - 1)) begin
          r_frame_cnt <= '0;
          r_game_tick <= 1'b1;
        end else begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
        end
      end
    end
  end

  assign hCount     = r_h;
  assign vCount     = r_v;
  assign bright     = w_bright;
  assign pix_en     = w_pix_en;
  assign hSync      = r_hsync;
  assign vSync      = r_vsync;
  assign vga_r      = r_vga_r;
  assign vga_g      = r_vga_g;
  assign vga_b      = r_vga_b;
  assign frame_tick = r_frame_tick;
  assign game_tick  = r_game_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  // Reduced raster so several whole frames fit in a short run.
  localparam int D   = 4;
  localparam int HT  = 40;
  localparam int HS  = 6;
  localparam int HAS = 9;
  localparam int HAE = 37;
  localparam int VT  = 20;
  localparam int VS  = 2;
  localparam int VAS = 4;
  localparam int VAE = 18;
  localparam int FPT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rgb_in;

  logic [9:0]  s_h, s_v;
  logic        s_bright, s_pix_en, s_hsync, s_vsync, s_ft, s_gt;
  logic [3:0]  s_r, s_g, s_b;

  logic [9:0]  d_h, d_v;
  logic        d_bright, d_pix_en, d_hsync, d_vsync, d_ft, d_gt;
  logic [3:0]  d_r, d_g, d_b;

  int k = 0;
  int checks = 0;
  int errors = 0;
  bit phase2 = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE),
    .FRAMES_PER_TICK(FPT)
  ) u_dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in),
    .hCount(s_h), .vCount(s_v), .bright(s_bright), .pix_en(s_pix_en),
    .hSync(s_hsync), .vSync(s_vsync), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .frame_tick(s_ft), .game_tick(s_gt)
  );

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .rgb_in(rgb_in),
    .hCount(d_h), .vCount(d_v), .bright(d_bright), .pix_en(d_pix_en),
    .hSync(d_hsync), .vSync(d_vsync), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .frame_tick(d_ft), .game_tick(d_gt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic in_act(input int h, input int v);
    return (h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE);
  endfunction

  // Stimulus colour for a raster position: a marker at the first visible
  // pixel, white in the left blanking area, and a position pattern elsewhere.
  function automatic logic [11:0] rgb_func(input int h, input int v);
    if (h == HAS && v == VAS) return 12'hF00;
    if (h < HAS) return 12'hFFF;
    return {4'(h), 4'(v), 4'(h + v)};
  endfunction

  // After k edges since reset release, floor(k/D) pixel advances have happened.
  function automatic logic [37:0] model(input int kk);
    int n, h, v, p, ph, pv;
    logic pe, hs, vs, ft, gt;
    logic [11:0] col;
    n  = kk / D;
    h  = n % HT;
    v  = (n / HT) % VT;
    pe = ((kk % D) == D - 1);
    if (n == 0) begin
      hs = 1'b1; vs = 1'b1; col = 12'h000;
    end else begin
      p  = n - 1;
      ph = p % HT;
      pv = (p / HT) % VT;
      hs = !(ph < HS);
      vs = !(pv < VS);
      col = in_act(ph, pv) ? rgb_func(ph, pv) : 12'h000;
    end
    ft = ((kk % D) == 0) && (n > 0) && ((n % (HT * VT)) == 0);
    gt = ((kk % D) == 0) && (n > 0) && ((n % (HT * VT * FPT)) == 0);
    return {10'(h), 10'(v), in_act(h, v), pe, hs, vs, col, ft, gt};
  endfunction

  assign rgb_in = rgb_func((k / D) % HT, ((k / D) / HT) % VT);

  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  // Cycle-by-cycle comparison of the reduced-raster instance against the model.
  logic [37:0] s_act;
  assign s_act = {s_h, s_v, s_bright, s_pix_en, s_hsync, s_vsync, s_r, s_g, s_b, s_ft, s_gt};

  always @(negedge clk) begin
    if (!rst) chk($sformatf("cycle k=%0d", k), 64'(s_act), 64'(model(k)));
  end

  // Directed literal checks and measurements after the mid-frame reset.
  int bt_h [8] = '{8, 9, 36, 37, 9, 9, 9, 36};
  int bt_v [8] = '{4, 4, 4, 4, 3, 17, 18, 17};
  bit bt_e [8] = '{0, 1, 1, 0, 0, 1, 0, 1};
  bit bt_hit [8];
  bit rgb_hit0 = 0, rgb_hit1 = 0;
  int hs_low = 0, vs_low = 0, d_hs_low = 0, d_vs_low = 0;
  int d_first_wrap = 0;
  int gt_alone = 0;
  logic [17:0] d_any = '0;
  int ft_q[$];
  int gt_q[$];

  always @(negedge clk) begin
    if (phase2 && !rst) begin
      if (k == 2) chk("pix_en_k2", 64'(s_pix_en), 64'd0);
      if (k == 3) chk("first_pix_en_k3", 64'({s_pix_en, s_h}), 64'({1'b1, 10'd0}));
      if (k == 4) chk("h_adv_k4", 64'({s_pix_en, s_h}), 64'({1'b0, 10'd1}));
      if (k == 7) chk("pix_en_k7", 64'(s_pix_en), 64'd1);
      if (k >= 1 && k <= 3200) begin
        if (!s_hsync) hs_low++;
        if (!s_vsync) vs_low++;
      end
      if (s_ft) ft_q.push_back(k);
      if (s_gt) gt_q.push_back(k);
      if (s_gt && !s_ft) gt_alone++;
      for (int i = 0; i < 8; i++) begin
        if (!bt_hit[i] && s_h == 10'(bt_h[i]) && s_v == 10'(bt_v[i])) begin
          bt_hit[i] = 1'b1;
          chk($sformatf("bright(%0d,%0d)", bt_h[i], bt_v[i]), 64'(s_bright), 64'(bt_e[i]));
        end
      end
      if (!rgb_hit0 && s_h == 10'(HAS + 1) && s_v == 10'(VAS)) begin
        rgb_hit0 = 1'b1;
        chk("rgb_F00_out", 64'({s_r, s_g, s_b}), 64'h F00);
      end
      if (!rgb_hit1 && s_h == 10'd6 && s_v == 10'(VAS)) begin
        rgb_hit1 = 1'b1;
        chk("rgb_FFF_blanked", 64'({s_r, s_g, s_b}), 64'h000);
      end
      if (k == 3199) chk("def_h799", 64'({d_pix_en, d_h, d_v}), 64'({1'b1, 10'd799, 10'd0}));
      if (k >= 1 && k <= 6400) begin
        if (!d_hsync) d_hs_low++;
        if (!d_vsync) d_vs_low++;
        d_any = d_any | {d_bright, d_r, d_g, d_b, d_ft, d_gt};
      end
      if (d_first_wrap == 0 && d_h == 10'd0 && d_v == 10'd1) d_first_wrap = k;
    end
  end

  int exp_ft [4] = '{3200, 6400, 9600, 12800};
  int exp_gt [2] = '{6400, 12800};

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (s_h == 10'd20 && s_v == 10'd10) found = 1'b1;
    end
    chk("reach_mid_frame", 64'(found), 64'd1);

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_state", 64'(s_act), 64'({10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0}));
    chk("mid_reset_def", 64'({d_h, d_v, d_hsync, d_vsync}), 64'({10'd0, 10'd0, 1'b1, 1'b1}));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    phase2 = 1'b1;

    repeat (13000) @(negedge clk);

    chk("hsync_low_clks_frame", 64'(hs_low), 64'd480);
    chk("vsync_low_clks_frame", 64'(vs_low), 64'd320);
    chk("frame_tick_count", 64'(ft_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < ft_q.size(); i++)
      chk($sformatf("frame_tick_at[%0d]", i), 64'(ft_q[i]), 64'(exp_ft[i]));
    chk("game_tick_count", 64'(gt_q.size()), 64'd2);
    for (int i = 0; i < 2 && i < gt_q.size(); i++)
      chk($sformatf("game_tick_at[%0d]", i), 64'(gt_q[i]), 64'(exp_gt[i]));
    chk("game_tick_alone", 64'(gt_alone), 64'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bright_visited[%0d]", i), 64'(bt_hit[i]), 64'd1);
    chk("rgb_points_visited", 64'({rgb_hit0, rgb_hit1}), 64'b11);
    chk("def_line_wrap_clk", 64'(d_first_wrap), 64'd3200);
    chk("def_hsync_low_clks", 64'(d_hs_low), 64'd768);
    chk("def_vsync_low_clks", 64'(d_vs_low), 64'd6397);
    chk("def_blank_outputs", 64'(d_any), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
